// File: rtl/scontrol_top.sv
// Power-stage controller: decodes strobed 3-bit commands into H-bridge gate patterns,
// runs the precharge/start sequence and latches fault indications.
module scontrol_top #(
   parameter int unsigned FREQ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic I_CLK,
   input  logic I_C0,
   input  logic I_C1,
   input  logic I_C2,
   input  logic I_BT,
   input  logic I_ERR_DR_1,
   input  logic I_ERR_DR_2,
   input  logic I_ERR_DR_3,
   input  logic I_ERR_DR_4,
   input  logic I_ERR_I,
   input  logic I_ERR_U,
   input  logic I_STOP_K,
   output logic O_TOP_1,
   output logic O_TOP_2,
   output logic O_TOP_3,
   output logic O_TOP_4,
   output logic O_BOT_1,
   output logic O_BOT_2,
   output logic O_BOT_3,
   output logic O_BOT_4,
   output logic O_PLUS,
   output logic O_MINUS,
   output logic O_PAUSE_P,
   output logic O_PAUSE_N,
   output logic O_FAN,
   output logic O_CHARGE,
   output logic O_ST,
   output logic O_CH,
   output logic O_START,
   output logic O_BREAK,
   output logic O_ERBD1,
   output logic O_ERBD2,
   output logic O_ERBD3,
   output logic O_ERBD4,
   output logic O_AVI,
   output logic O_AVV,
   output logic O_STOP,
   output logic O_TD,
   output logic led_ready,
   output logic led_done
);

   localparam int unsigned TW = $clog2(16 * FREQ);
   localparam logic [TW-1:0] T_ST  = TW'(15 * FREQ - 1);
   localparam logic [TW-1:0] T_RDY = TW'(15 * FREQ + FREQ / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRECH, S_READY, S_FAULT} state_t;
   typedef enum logic [2:0] {M_OFF = 3'd0, M_PLUS = 3'd1, M_MINUS = 3'd2,
                             M_BALP = 3'd3, M_BALN = 3'd4} mode_t;
   typedef enum logic [2:0] {A_IDLE, A_7, A_70, A_707, A_7070} arm_t;

   logic [1:0]    strb_sync;
   logic          strb_prev;
   logic [2:0]    cmd_s1, cmd_s2;
   logic [6:0]    flt_s1, flt_s2;
   logic          bt_s1, bt_s2;

   logic          strobe;
   logic [2:0]    cmd;
   logic [6:0]    fault_act;
   logic          fault_in;
   logic [6:0]    flags_q;

   state_t        state, nxt_state;
   mode_t         mode, nxt_mode;
   arm_t          arm, nxt_arm;
   logic [TW-1:0] timer, nxt_timer;
   logic          nxt_fan, nxt_charge, nxt_st, nxt_ch, nxt_start, nxt_brk, nxt_td;
   logic [6:0]    nxt_flags;
   logic          do_shut;

   function automatic logic [3:0] top_of(input mode_t m);
      case (m)
         M_PLUS:  return 4'b0001;
         M_MINUS: return 4'b0010;
         M_BALP:  return 4'b0100;
         M_BALN:  return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] bot_of(input mode_t m);
      case (m)
         M_PLUS:  return 4'b0010;
         M_MINUS: return 4'b0001;
         M_BALP:  return 4'b1000;
         M_BALN:  return 4'b0100;
         default: return 4'b0000;
      endcase
   endfunction

   // Active-low fault inputs reset to their inactive level so reset never latches a fault.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         strb_sync <= '0;
         strb_prev <= 1'b0;
         cmd_s1    <= '0;
         cmd_s2    <= '0;
         flt_s1    <= '1;
         flt_s2    <= '1;
         bt_s1     <= 1'b0;
         bt_s2     <= 1'b0;
      end else begin
         strb_sync <= {strb_sync[0], I_CLK};
         strb_prev <= strb_sync[1];
         cmd_s1    <= {I_C2, I_C1, I_C0};
         cmd_s2    <= cmd_s1;
         flt_s1    <= {I_STOP_K, I_ERR_U, I_ERR_I, I_ERR_DR_4, I_ERR_DR_3, I_ERR_DR_2, I_ERR_DR_1};
         flt_s2    <= flt_s1;
         bt_s1     <= I_BT;
         bt_s2     <= bt_s1;
      end
   end

   assign strobe    = strb_sync[1] & ~strb_prev;
   assign cmd       = cmd_s2;
   assign fault_act = ~flt_s2;
   assign fault_in  = |fault_act;
   assign flags_q   = {O_STOP, O_AVV, O_AVI, O_ERBD4, O_ERBD3, O_ERBD2, O_ERBD1};

   always_comb begin
      nxt_state  = state;
      nxt_mode   = mode;
      nxt_arm    = arm;
      nxt_timer  = timer;
      nxt_fan    = O_FAN;
      nxt_charge = O_CHARGE;
      nxt_st     = O_ST;
      nxt_ch     = O_CH;
      nxt_start  = O_START;
      nxt_brk    = O_BREAK;
      nxt_td     = O_TD ^ strobe;
      do_shut    = 1'b0;
      nxt_flags  = flags_q | fault_act;
      if (strobe && cmd == 3'd6)
         nxt_flags = fault_act;

      if (state == S_PRECH) begin
         nxt_timer = timer + 1'b1;
         if (timer == T_ST)
            nxt_st = 1'b1;
         if (timer == T_RDY) begin
            nxt_state  = S_READY;
            nxt_charge = 1'b0;
            nxt_ch     = 1'b1;
            nxt_start  = 1'b0;
         end
      end

      if (strobe) begin
         // Overlapping matcher for the 7,0,7,0 arm prefix
         case (arm)
            A_IDLE:  nxt_arm = (cmd == 3'd7) ? A_7 : A_IDLE;
            A_7:     nxt_arm = (cmd == 3'd0) ? A_70 : (cmd == 3'd7) ? A_7 : A_IDLE;
            A_70:    nxt_arm = (cmd == 3'd7) ? A_707 : A_IDLE;
            A_707:   nxt_arm = (cmd == 3'd0) ? A_7070 : (cmd == 3'd7) ? A_7 : A_IDLE;
            A_7070:  nxt_arm = (cmd == 3'd7) ? A_707 : A_IDLE;
            default: nxt_arm = A_IDLE;
         endcase

         if (state == S_FAULT) begin
            nxt_arm = A_IDLE;
            if (cmd == 3'd6)
               do_shut = 1'b1;
         end else if (arm == A_7070 && (cmd == 3'd1 || cmd == 3'd3)) begin
            nxt_brk  = 1'b1;
            nxt_mode = (cmd == 3'd3) ? M_BALP : M_OFF;
         end else begin
            case (cmd)
               3'd0: nxt_mode = M_OFF;
               3'd1, 3'd2, 3'd3, 3'd4:
                  nxt_mode = (state == S_READY && !bt_s2) ? mode_t'(cmd) : M_OFF;
               3'd5: begin
                  if (state == S_IDLE) begin
                     nxt_state  = S_PRECH;
                     nxt_timer  = '0;
                     nxt_fan    = 1'b1;
                     nxt_charge = 1'b1;
                     nxt_start  = 1'b1;
                     nxt_st     = 1'b0;
                     nxt_mode   = M_OFF;
                  end
               end
               3'd6: do_shut = 1'b1;
               default: ;
            endcase
         end
      end

      if (do_shut) begin
         nxt_state  = S_IDLE;
         nxt_mode   = M_OFF;
         nxt_timer  = '0;
         nxt_fan    = 1'b0;
         nxt_charge = 1'b0;
         nxt_st     = 1'b0;
         nxt_ch     = 1'b0;
         nxt_start  = 1'b0;
         nxt_brk    = 1'b0;
      end

      // A live fault overrides any command decoded in the same cycle
      if (fault_in) begin
         nxt_state  = S_FAULT;
         nxt_mode   = M_OFF;
         nxt_timer  = '0;
         nxt_charge = 1'b0;
         nxt_st     = 1'b0;
         nxt_start  = 1'b0;
      end
      if (bt_s2)
         nxt_mode = M_OFF;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         mode      <= M_OFF;
         arm       <= A_IDLE;
         timer     <= '0;
         {O_TOP_4, O_TOP_3, O_TOP_2, O_TOP_1} <= '0;
         {O_BOT_4, O_BOT_3, O_BOT_2, O_BOT_1} <= '0;
         O_PLUS    <= 1'b0;
         O_MINUS   <= 1'b0;
         O_PAUSE_P <= 1'b0;
         O_PAUSE_N <= 1'b0;
         O_FAN     <= 1'b0;
         O_CHARGE  <= 1'b0;
         O_ST      <= 1'b0;
         O_CH      <= 1'b0;
         O_START   <= 1'b0;
         O_BREAK   <= 1'b0;
         {O_STOP, O_AVV, O_AVI, O_ERBD4, O_ERBD3, O_ERBD2, O_ERBD1} <= '0;
         O_TD      <= 1'b0;
         led_ready <= 1'b0;
         led_done  <= 1'b0;
      end else begin
         state     <= nxt_state;
         mode      <= nxt_mode;
         arm       <= nxt_arm;
         timer     <= nxt_timer;
         {O_TOP_4, O_TOP_3, O_TOP_2, O_TOP_1} <= top_of(nxt_mode);
         {O_BOT_4, O_BOT_3, O_BOT_2, O_BOT_1} <= bot_of(nxt_mode);
         O_PLUS    <= (nxt_mode == M_PLUS);
         O_MINUS   <= (nxt_mode == M_MINUS);
         O_PAUSE_P <= (nxt_mode == M_BALP);
         O_PAUSE_N <= (nxt_mode == M_BALN);
         O_FAN     <= nxt_fan;
         O_CHARGE  <= nxt_charge;
         O_ST      <= nxt_st;
         O_CH      <= nxt_ch;
         O_START   <= nxt_start;
         O_BREAK   <= nxt_brk;
         {O_STOP, O_AVV, O_AVI, O_ERBD4, O_ERBD3, O_ERBD2, O_ERBD1} <= nxt_flags;
         O_TD      <= nxt_td;
         led_ready <= nxt_st & ~(|nxt_flags);
         led_done  <= nxt_brk;
      end
   end

endmodule

// File: tb/tb_scontrol_top.sv
// Scoreboard bench for scontrol_top: every strobed command pushes the expected output
// snapshot; a monitor compares it when O_TD toggles. Timed sequences are checked inline.
module tb_scontrol_top;
   localparam int FREQ = 400;
   localparam int P_IDLE = 0, P_PRECH = 1, P_READY = 2, P_FAULT = 3;

   logic clk = 1'b0, rst = 1'b0;
   logic I_CLK = 1'b0, I_C0 = 1'b0, I_C1 = 1'b0, I_C2 = 1'b0, I_BT = 1'b0;
   logic I_ERR_DR_1 = 1'b1, I_ERR_DR_2 = 1'b1, I_ERR_DR_3 = 1'b1, I_ERR_DR_4 = 1'b1;
   logic I_ERR_I = 1'b1, I_ERR_U = 1'b1, I_STOP_K = 1'b1;
   logic O_TOP_1, O_TOP_2, O_TOP_3, O_TOP_4, O_BOT_1, O_BOT_2, O_BOT_3, O_BOT_4;
   logic O_PLUS, O_MINUS, O_PAUSE_P, O_PAUSE_N, O_FAN, O_CHARGE, O_ST, O_CH, O_START, O_BREAK;
   logic O_ERBD1, O_ERBD2, O_ERBD3, O_ERBD4, O_AVI, O_AVV, O_STOP, O_TD, led_ready, led_done;

   int checks = 0, errors = 0, cyc = 0;

   // Reference model state
   int         m_phase, m_mode;
   bit         m_fan, m_charge, m_st, m_ch, m_start, m_brk, m_bt;
   bit   [6:0] m_flt;
   int         hist[$];
   logic [3:0] top_tbl [0:4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
   logic [3:0] bot_tbl [0:4] = '{4'b0000, 4'b0010, 4'b0001, 4'b1000, 4'b0100};

   logic [26:0] exp_q[$];
   int          cmd_q[$];

   scontrol_top #(.FREQ(FREQ)) dut (
      .clk(clk), .rst(rst), .I_CLK(I_CLK), .I_C0(I_C0), .I_C1(I_C1), .I_C2(I_C2), .I_BT(I_BT),
      .I_ERR_DR_1(I_ERR_DR_1), .I_ERR_DR_2(I_ERR_DR_2), .I_ERR_DR_3(I_ERR_DR_3),
      .I_ERR_DR_4(I_ERR_DR_4), .I_ERR_I(I_ERR_I), .I_ERR_U(I_ERR_U), .I_STOP_K(I_STOP_K),
      .O_TOP_1(O_TOP_1), .O_TOP_2(O_TOP_2), .O_TOP_3(O_TOP_3), .O_TOP_4(O_TOP_4),
      .O_BOT_1(O_BOT_1), .O_BOT_2(O_BOT_2), .O_BOT_3(O_BOT_3), .O_BOT_4(O_BOT_4),
      .O_PLUS(O_PLUS), .O_MINUS(O_MINUS), .O_PAUSE_P(O_PAUSE_P), .O_PAUSE_N(O_PAUSE_N),
      .O_FAN(O_FAN), .O_CHARGE(O_CHARGE), .O_ST(O_ST), .O_CH(O_CH), .O_START(O_START),
      .O_BREAK(O_BREAK), .O_ERBD1(O_ERBD1), .O_ERBD2(O_ERBD2), .O_ERBD3(O_ERBD3),
      .O_ERBD4(O_ERBD4), .O_AVI(O_AVI), .O_AVV(O_AVV), .O_STOP(O_STOP), .O_TD(O_TD),
      .led_ready(led_ready), .led_done(led_done)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [26:0] obs();
      return {O_TOP_4, O_TOP_3, O_TOP_2, O_TOP_1, O_BOT_4, O_BOT_3, O_BOT_2, O_BOT_1,
              O_PLUS, O_MINUS, O_PAUSE_P, O_PAUSE_N,
              O_FAN, O_CHARGE, O_ST, O_CH, O_START, O_BREAK,
              O_STOP, O_AVV, O_AVI, O_ERBD4, O_ERBD3, O_ERBD2, O_ERBD1, led_ready, led_done};
   endfunction

   function automatic logic [26:0] exp_vec();
      logic [3:0] t, b;
      t = top_tbl[m_mode];
      b = bot_tbl[m_mode];
      return {t, b, m_mode == 1, m_mode == 2, m_mode == 3, m_mode == 4,
              m_fan, m_charge, m_st, m_ch, m_start, m_brk, m_flt, m_st & ~(|m_flt), m_brk};
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_mode = 0; m_fan = 0; m_charge = 0; m_st = 0; m_ch = 0;
      m_start = 0; m_brk = 0; m_flt = '0; hist.delete();
   endtask

   task automatic model_shutdown();
      m_phase = P_IDLE; m_mode = 0; m_fan = 0; m_charge = 0; m_st = 0; m_ch = 0;
      m_start = 0; m_brk = 0; m_flt = '0;
   endtask

   task automatic model_cmd(input int c);
      bit armed;
      if (m_phase == P_FAULT) begin
         hist.delete();
         if (c == 6) model_shutdown();
      end else begin
         armed = hist.size() == 4 && hist[0] == 7 && hist[1] == 0 && hist[2] == 7 && hist[3] == 0;
         hist.push_back(c);
         if (hist.size() > 4) void'(hist.pop_front());
         if (armed && (c == 1 || c == 3)) begin
            m_brk = 1;
            m_mode = (c == 3) ? 3 : 0;
            hist.delete();
         end else begin
            case (c)
               0: m_mode = 0;
               1, 2, 3, 4: m_mode = (m_phase == P_READY && !m_bt) ? c : 0;
               5: if (m_phase == P_IDLE) begin
                     m_phase = P_PRECH; m_fan = 1; m_charge = 1; m_start = 1; m_st = 0; m_mode = 0;
                  end
               6: model_shutdown();
               default: ;
            endcase
         end
      end
      if (m_bt) m_mode = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, got, want);
      end
   endtask

   task automatic strobe_cmd(input int c);
      {I_C2, I_C1, I_C0} = 3'(c);
      repeat (3) @(posedge clk);
      #1 I_CLK = 1'b1;
   endtask

   task automatic send_cmd(input int c);
      model_cmd(c);
      exp_q.push_back(exp_vec());
      cmd_q.push_back(c);
      strobe_cmd(c);
      repeat (6) @(posedge clk);
      #1 I_CLK = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      int t_clk, latch, st_t, n;
      model_cmd(5);
      exp_q.push_back(exp_vec());
      cmd_q.push_back(5);
      strobe_cmd(5);
      t_clk = cyc;
      n = 0;
      @(negedge clk);
      while (!O_CHARGE && n < 10) begin @(negedge clk); n++; end
      latch = cyc;
      chk("start latency", (latch - t_clk >= 1) && (latch - t_clk <= 4), 1);
      repeat (4) @(negedge clk);
      chk("precharge ST low", O_ST, 0);
      I_CLK = 1'b0;
      n = 0;
      while (!O_ST && n < 16 * FREQ) begin @(negedge clk); n++; end
      chk("ST delay from latch", cyc - latch, 15 * FREQ);
      chk("CHARGE held at ST", O_CHARGE, 1);
      st_t = cyc;
      n = 0;
      while (O_CHARGE && n < FREQ) begin @(negedge clk); n++; end
      chk("CHARGE off after ST", cyc - st_t, FREQ / 2);
      m_phase = P_READY; m_st = 1; m_charge = 0; m_ch = 1; m_start = 0;
      chk("ready snapshot", obs(), exp_vec());
      @(posedge clk);
      #1;
   endtask

   // Monitor: one response per O_TD toggle
   logic td_seen = 1'b0;
   always @(negedge clk) begin : mon
      logic [26:0] e;
      int c;
      if (!rst) td_seen = 1'b0;
      else if (O_TD !== td_seen) begin
         td_seen = O_TD;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected response: outputs %b with no command pending", obs());
         end else begin
            e = exp_q.pop_front();
            c = cmd_q.pop_front();
            if (obs() !== e) begin
               errors++;
               $display("FAIL cmd%0d response: got %b, expected %b", c, obs(), e);
            end
         end
      end
   end

   int pick[6] = '{0, 1, 2, 3, 4, 7};

   initial begin : main
      int r, n;
      m_bt = 0;
      model_reset();
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset outputs", {4'b0, obs(), O_TD}, 0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk); #1;

      send_cmd(1);                 // bridge must stay off before start
      do_start();

      for (int i = 0; i < 10; i++) begin send_cmd(1); send_cmd(2); end
      send_cmd(3); send_cmd(4); send_cmd(0);

      send_cmd(1);
      I_BT = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      m_bt = 1; m_mode = 0;
      chk("bridge inhibit", obs(), exp_vec());
      @(posedge clk); #1;
      send_cmd(2);
      I_BT = 1'b0; m_bt = 0;
      repeat (4) @(posedge clk); #1;

      for (int i = 0; i < 150; i++) begin
         r = int'($urandom_range(0, 19));
         if (r < 2) begin
            send_cmd(7); send_cmd(0); send_cmd(7); send_cmd(0); send_cmd(r == 0 ? 1 : 3);
         end else if (r == 2) send_cmd(6);
         else send_cmd(pick[$urandom_range(0, 5)]);
      end

      send_cmd(6);
      do_start();
      send_cmd(1);
      @(posedge clk); #1 I_ERR_I = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("fault bridge off", {O_TOP_4, O_TOP_3, O_TOP_2, O_TOP_1, O_BOT_4, O_BOT_3, O_BOT_2,
                               O_BOT_1, O_PLUS, O_MINUS, O_PAUSE_P, O_PAUSE_N}, 0);
      m_phase = P_FAULT; m_flt[4] = 1; m_mode = 0; m_charge = 0; m_st = 0; m_start = 0;
      hist.delete();
      chk("fault snapshot", obs(), exp_vec());
      @(posedge clk); #1 I_ERR_I = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("AVI latched after release", O_AVI, 1);
      @(posedge clk); #1;
      send_cmd(1);
      send_cmd(6);

      send_cmd(7); send_cmd(0); send_cmd(1);
      send_cmd(7); send_cmd(0); send_cmd(7); send_cmd(0); send_cmd(1);
      send_cmd(6);
      send_cmd(7); send_cmd(0); send_cmd(7); send_cmd(0); send_cmd(3);
      send_cmd(6);

      model_cmd(5);
      exp_q.push_back(exp_vec());
      cmd_q.push_back(5);
      strobe_cmd(5);
      repeat (50) @(posedge clk);
      #1 rst = 1'b0; I_CLK = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset mid-sequence", {4'b0, obs(), O_TD}, 0);
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk); #1;
      send_cmd(2);

      n = 0;
      while (exp_q.size() > 0 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d responses missing, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
